// File: rtl/hd44780_ram_sequencer.sv
// rtl/hd44780_ram_sequencer.sv - walks hd44780_ram words and plays them as LCD commands, delays and stops
// Issues command bytes over a valid/ready handshake; RAM is read one word at a time through its registered port.
module hd44780_ram_sequencer #(
    parameter int addr_width = 8,
    parameter int delay_unit = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [addr_width-1:0] start_addr,
    output logic                  busy,
    output logic                  done,
    output logic                  overrun,
    output logic [addr_width-1:0] ram_raddr,
    input  logic [15:0]           ram_rdata,
    output logic                  cmd_valid,
    input  logic                  cmd_ready,
    output logic                  cmd_rs,
    output logic [7:0]            cmd_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_DECODE,
        S_ISSUE,
        S_DELAY
    } state_t;

    // Counter must hold the largest delay word times delay_unit without truncation.
    localparam longint unsigned MAX_DELAY = longint'(16383) * longint'(delay_unit);
    localparam int CNT_W = $clog2(MAX_DELAY + 1);
    localparam logic [CNT_W-1:0] DU = CNT_W'(delay_unit);
    localparam logic [addr_width-1:0] LAST_ADDR = '1;

    state_t                state_q, state_d;
    logic [addr_width-1:0] raddr_q, raddr_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  overrun_q, overrun_d;
    logic                  cmd_valid_q, cmd_valid_d;
    logic                  cmd_rs_q, cmd_rs_d;
    logic [7:0]            cmd_data_q, cmd_data_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  advance;
    logic [CNT_W-1:0]      delay_load;

    assign delay_load = (CNT_W'(ram_rdata[13:0]) * DU) - CNT_W'(1);

    always_comb begin
        state_d     = state_q;
        raddr_d     = raddr_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        overrun_d   = overrun_q;
        cmd_valid_d = cmd_valid_q;
        cmd_rs_d    = cmd_rs_q;
        cmd_data_d  = cmd_data_q;
        cnt_d       = cnt_q;
        advance     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    raddr_d   = start_addr;
                    busy_d    = 1'b1;
                    overrun_d = 1'b0;
                    state_d   = S_READ;
                end
            end
            S_READ: begin
                state_d = S_DECODE;
            end
            S_DECODE: begin
                if (ram_rdata[15]) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else if (ram_rdata[14]) begin
                    if (ram_rdata[13:0] == 14'd0) begin
                        advance = 1'b1;
                    end else begin
                        cnt_d   = delay_load;
                        state_d = S_DELAY;
                    end
                end else begin
                    cmd_rs_d    = ram_rdata[8];
                    cmd_data_d  = ram_rdata[7:0];
                    cmd_valid_d = 1'b1;
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (cmd_ready) begin
                    cmd_valid_d = 1'b0;
                    advance     = 1'b1;
                end
            end
            S_DELAY: begin
                if (cnt_q == '0) begin
                    advance = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Running past the last word ends the script rather than wrapping to 0.
        if (advance) begin
            if (raddr_q == LAST_ADDR) begin
                state_d   = S_IDLE;
                busy_d    = 1'b0;
                done_d    = 1'b1;
                overrun_d = 1'b1;
            end else begin
                raddr_d = raddr_q + addr_width'(1);
                state_d = S_READ;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            raddr_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            overrun_q   <= 1'b0;
            cmd_valid_q <= 1'b0;
            cmd_rs_q    <= 1'b0;
            cmd_data_q  <= 8'd0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            raddr_q     <= raddr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            overrun_q   <= overrun_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_rs_q    <= cmd_rs_d;
            cmd_data_q  <= cmd_data_d;
            cnt_q       <= cnt_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign overrun   = overrun_q;
    assign ram_raddr = raddr_q;
    assign cmd_valid = cmd_valid_q;
    assign cmd_rs    = cmd_rs_q;
    assign cmd_data  = cmd_data_q;

endmodule
